mux_n_reg: RTL and testbench
============================

MUX_N_REG -- requirements
Module: mux_n_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, input channel count, legal range 2..16.
REQ-003 SHALL have local parameter SEL_W, equal to $clog2(CHANNELS), select/index width.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_data, input, CHANNELS*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid, input, CHANNELS, per-channel valid.
REQ-008 SHALL have port in_ready, output, CHANNELS, per-channel ready.
REQ-009 SHALL have port sel, input, SEL_W, channel select in fixed mode.
REQ-010 SHALL have port mode, input, 1, 0 = fixed select, 1 = round-robin.
REQ-011 SHALL have port out_data, output, WIDTH, registered selected word.
REQ-012 SHALL have port out_chan, output, SEL_W, index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid, output, 1, out_data holds an undelivered word.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts the word.

Function
REQ-015 SHALL contain a one-entry output register (out_data, out_chan, out_valid); load_en = !out_valid || out_ready.
REQ-016 In fixed mode, the chosen channel SHALL be sel; if sel >= CHANNELS, no channel is chosen and all in_ready SHALL be 0.
REQ-017 In round-robin mode, the chosen channel SHALL be the first i with in_valid[i] set, scanning ptr, ptr+1, ... and wrapping modulo CHANNELS.
REQ-018 in_ready[i] SHALL be 1 iff load_en and i is the chosen channel; all other in_ready bits SHALL be 0 (combinational, at most one bit set).
REQ-019 A transfer SHALL occur when in_valid[i] && in_ready[i]; on the next edge out_data = word i, out_chan = i, out_valid = 1 (latency 1 cycle).
REQ-020 When out_valid && out_ready with no transfer, out_valid SHALL clear on the next edge; out_data and out_chan SHALL hold their values.
REQ-021 Simultaneous delivery (out_valid && out_ready) and transfer SHALL replace the word in the same edge: no bubble, no loss, no duplication.
REQ-022 While out_valid && !out_ready, out_data and out_chan SHALL stay stable and no in_ready SHALL be asserted.
REQ-023 The round-robin pointer ptr SHALL update to (granted index + 1) mod CHANNELS only on a transfer in round-robin mode, and hold otherwise.
REQ-024 Changing mode or sel SHALL affect only the next choice, never the registered word.
REQ-025 Sustained throughput SHALL be one word per cycle when out_ready stays high.

Reset
REQ-026 rst SHALL asynchronously force out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
REQ-027 Reset while a word is held SHALL discard that word; in_ready SHALL be 0 while rst is high.
REQ-028 The first transfer after rst deasserts SHALL be possible on the first rising edge with rst low.

Configuration
REQ-029 Macro MUX_N_REG_RR_EN SHALL compile in round-robin mode (ptr register and scan logic).
REQ-030 Without MUX_N_REG_RR_EN, the mode input SHALL be ignored, the block SHALL always behave as fixed mode, and ptr SHALL not exist.

Verification (CHANNELS=4, WIDTH=32)
REQ-031 Fixed mode, sel=2, in_valid=4'b0100, in_data ch2=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=DEADBEEF, out_chan=2, out_valid=1.
REQ-032 Fixed mode, sel=1, in_valid=4'b1111, out_ready=0 for 3 cycles after first load -> out_data stays ch1 word, in_ready=0 during stall; out_ready=1 -> next ch1 word is loaded with no bubble.
REQ-033 RR mode (macro defined), in_valid=4'b1111 held, out_ready=1, words 0xA0..0xA3 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 RR mode, ptr=3, in_valid=4'b0010 -> grant to ch1 (wrap-around), ptr becomes 2.
REQ-035 Word held (out_valid=1, out_ready=0), rst pulsed mid-cycle -> out_valid=0, out_data=0, out_chan=0 immediately, without waiting for a clock edge; first post-reset edge accepts new word.
REQ-036 Build without MUX_N_REG_RR_EN, mode=1, sel=3, in_valid=4'b1001 -> only ch3 is granted.

Source files
------------

// File: rtl/mux_n_reg.sv
// mux_n_reg: N-channel valid/ready multiplexer feeding a one-entry output
// register. Channel choice is either a fixed select (sel) or, when the
// MUX_N_REG_RR_EN macro is defined, a round-robin scan selected by mode.
// Without MUX_N_REG_RR_EN the mode input is ignored and no pointer exists.
//
// Handshake: a word moves across an interface on a rising edge where
// valid && ready are both high. Valid never waits on ready. On the input
// side at most one in_ready bit is high, and only while the output
// register can load (empty, or being drained this same cycle). On the
// output side, out_data/out_chan are stable while out_valid && !out_ready.
module mux_n_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Channel count at index width plus one, so index arithmetic can wrap.
  localparam logic [SEL_W:0] CH_CNT = (SEL_W+1)'(CHANNELS);

  logic             load_en;
  logic             fx_ok;
  logic [SEL_W-1:0] fx_pick;
  logic             pick_ok;
  logic [SEL_W-1:0] pick;
  logic [WIDTH-1:0] pick_word;
  logic             xfer;

  // The output register can take a new word when empty or being drained.
  assign load_en = !out_valid || out_ready;

  // Fixed select: an out-of-range sel chooses nothing.
  always_comb begin
    fx_ok   = ({1'b0, sel} < CH_CNT);
    fx_pick = sel;
  end

`ifdef MUX_N_REG_RR_EN
  logic [SEL_W-1:0] ptr;
  logic             rr_ok;
  logic [SEL_W-1:0] rr_pick;
  logic [SEL_W-1:0] ptr_next;

  // Round-robin scan: first valid channel at ptr, ptr+1, ... modulo CHANNELS.
  always_comb begin
    logic [SEL_W:0] idx;
    rr_ok   = 1'b0;
    rr_pick = '0;
    idx     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = {1'b0, ptr} + (SEL_W+1)'(k);
      if (idx >= CH_CNT) begin
        idx = idx - CH_CNT;
      end
      if (!rr_ok && in_valid[idx[SEL_W-1:0]]) begin
        rr_ok   = 1'b1;
        rr_pick = idx[SEL_W-1:0];
      end
    end
  end

  // Mode picks between the round-robin and fixed choice.
  always_comb begin
    pick_ok = mode ? rr_ok   : fx_ok;
    pick    = mode ? rr_pick : fx_pick;
  end

  // Pointer advance value: one past the granted channel, wrapped.
  always_comb begin
    logic [SEL_W:0] nxt;
    nxt = {1'b0, pick} + (SEL_W+1)'(1);
    if (nxt >= CH_CNT) begin
      nxt = '0;
    end
    ptr_next = nxt[SEL_W-1:0];
  end

  // Pointer moves only when a round-robin grant actually transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer && mode) begin
      ptr <= ptr_next;
    end
  end
`else
  // mode has no meaning in this build; keep it visibly consumed.
  logic unused_mode;
  assign unused_mode = mode;

  // Fixed select is the only choice in this build.
  always_comb begin
    pick_ok = fx_ok;
    pick    = fx_pick;
  end
`endif

  // One-hot ready to the chosen channel; held low during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst && load_en && pick_ok && (pick == SEL_W'(i))) begin
        in_ready[i] = 1'b1;
      end
    end
  end

  // Word of the chosen channel.
  always_comb begin
    pick_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pick == SEL_W'(i)) begin
        pick_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Output register: load on transfer (also covers drain+refill in one
  // edge), clear valid on a drain without refill, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= pick_word;
      out_chan  <= pick;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// tb_mux_n_reg: directed and randomized checks of mux_n_reg (CHANNELS=4,
// WIDTH=32) against a behavioural model. Round-robin cases are built only
// when MUX_N_REG_RR_EN is defined, matching the DUT build.
module tb_mux_n_reg;
  localparam int W  = 32;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [SW-1:0]   sel;
  logic            mode;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  int total = 0;
  int bad   = 0;

  // Scoreboard of words accepted but not yet delivered: {chan, data}.
  logic [W+SW-1:0] exp_q[$];

  // Behavioural model state.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_chan;
  int           m_ptr;

  mux_n_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Channel the rules choose for the current inputs, -1 if none.
  function automatic int model_pick();
`ifdef MUX_N_REG_RR_EN
    if (mode) begin
      for (int k = 0; k < CH; k++) begin
        if (in_valid[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
      end
      return -1;
    end
`endif
    if (int'(sel) < CH) return int'(sel);
    return -1;
  endfunction

  // Driver: apply one cycle of inputs at negedge, check, then step the model.
  task automatic step(input logic [CH-1:0] v, input logic [CH*W-1:0] d,
                      input logic [SW-1:0] s, input logic md, input logic ordy,
                      input string tag);
    int              pick;
    logic [CH-1:0]   exp_rdy;
    logic            load;
    logic            xfer;
    logic            deliver;
    logic [W-1:0]    word;
    logic [W+SW-1:0] e;
    @(negedge clk);
    rst = 1'b0;
    in_valid = v; in_data = d; sel = s; mode = md; out_ready = ordy;
    #1;
    load    = !m_valid || ordy;
    pick    = model_pick();
    exp_rdy = '0;
    xfer    = 1'b0;
    word    = '0;
    if (load && pick >= 0) begin
      exp_rdy[pick] = 1'b1;
      xfer = v[pick];
      word = d[pick*W +: W];
    end
    deliver = m_valid && ordy;
    check({tag, "_rdy"}, in_ready, exp_rdy);
    check({tag, "_ov"}, out_valid, m_valid);
    check({tag, "_od"}, out_data, m_data);
    check({tag, "_oc"}, out_chan, m_chan);
    if (deliver) begin
      check({tag, "_sbq"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_sb"}, {out_chan, out_data}, e);
      end
    end
    if (xfer) exp_q.push_back({pick[SW-1:0], word});
    @(posedge clk);
    if (xfer) begin
      m_valid = 1'b1;
      m_data  = word;
      m_chan  = pick;
`ifdef MUX_N_REG_RR_EN
      if (md) m_ptr = (pick + 1) % CH;
`endif
    end else if (deliver) begin
      m_valid = 1'b0;
    end
  endtask

  // Mid-cycle asynchronous reset; leaves rst high across one edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    #1;
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_od"}, out_data, 0);
    check({tag, "_oc"}, out_chan, 0);
    check({tag, "_rdy"}, in_ready, 0);
    m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
    exp_q.delete();
    @(posedge clk);
  endtask

  function automatic logic [CH*W-1:0] rand_words();
    logic [CH*W-1:0] r;
    for (int i = 0; i < CH; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  initial begin
    logic [CH*W-1:0] d;
    int exp_seq[5];
    rst = 1'b1; in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
    m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", out_valid, 0);
    check("rst_od", out_data, 0);
    check("rst_oc", out_chan, 0);
    check("rst_rdy", in_ready, 0);

    // Fixed select of channel 2, first edge after reset release.
    d = '0; d[2*W +: W] = 32'hDEADBEEF;
    step(4'b0100, d, 2'd2, 1'b0, 1'b1, "f2");
    #1;
    check("f2_data", out_data, 32'hDEADBEEF);
    check("f2_chan", out_chan, 2);
    check("f2_valid", out_valid, 1);

    // Stall on channel 1 for three cycles, then refill with no bubble.
    d = rand_words();
    step(4'b1111, d, 2'd1, 1'b0, 1'b1, "st_load");
    step(4'b1111, rand_words(), 2'd1, 1'b0, 1'b0, "st0");
    step(4'b1111, rand_words(), 2'd1, 1'b0, 1'b0, "st1");
    step(4'b1111, rand_words(), 2'd1, 1'b0, 1'b0, "st2");
    #1;
    check("st_hold", out_data, d[1*W +: W]);
    d = rand_words();
    step(4'b1111, d, 2'd1, 1'b0, 1'b1, "st_go");
    #1;
    check("st_next", out_data, d[1*W +: W]);
    check("st_nv", out_valid, 1);

`ifdef MUX_N_REG_RR_EN
    do_reset("rr_rst");
    exp_seq = '{0, 1, 2, 3, 0};
    d = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, d, 2'd0, 1'b1, 1'b1, "rr_seq");
      #1;
      check("rr_chan", out_chan, exp_seq[i]);
      check("rr_data", out_data, 32'hA0 + exp_seq[i]);
    end
    // Pointer now 1: grant ch2 (ptr->3), then wrap to ch1 (ptr->2).
    step(4'b0100, d, 2'd0, 1'b1, 1'b1, "rr_c2");
    step(4'b0010, d, 2'd0, 1'b1, 1'b1, "rr_wrap");
    #1;
    check("rr_wrap_ch", out_chan, 1);
    step(4'b1111, d, 2'd0, 1'b1, 1'b1, "rr_after");
    #1;
    check("rr_after_ch", out_chan, 2);
`else
    // mode is ignored: fixed select of channel 3 only.
    d = rand_words();
    step(4'b1001, d, 2'd3, 1'b1, 1'b1, "nomode");
    #1;
    check("nomode_ch", out_chan, 3);
    check("nomode_d", out_data, d[3*W +: W]);
`endif

    // Reset while a word is held, then accept on the first edge after.
    step(4'b0001, rand_words(), 2'd0, 1'b0, 1'b0, "hold_ld");
    step(4'b0001, rand_words(), 2'd0, 1'b0, 1'b0, "hold");
    do_reset("mid_rst");
    d = rand_words();
    step(4'b0001, d, 2'd0, 1'b0, 1'b0, "post_rst");
    #1;
    check("post_rst_v", out_valid, 1);
    check("post_rst_d", out_data, d[W-1:0]);

    // Randomized traffic with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset("rnd_rst");
      step(CH'($urandom_range(0, 15)), rand_words(), SW'($urandom_range(0, CH-1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
